// File: rtl/cpu_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_fsm_if
// Description : Control/status bundle between cpu_ctrl_fsm and the datapath.
// Revision    : 1.0
// ============================================================================
interface cpu_ctrl_fsm_if;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       alu_src_sel;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       wb_sel;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       halted;
  logic       mem_error;
  logic       illegal_op;
  logic [3:0] state;

  // Controller side
  modport master (
    input  opcode, zero, mem_ready,
    output alu_src_sel, alu_op, reg_write, wb_sel, mem_read, mem_write,
           ir_write, pc_write, pc_src, halted, mem_error, illegal_op, state
  );

  // Datapath side
  modport slave (
    output opcode, zero, mem_ready,
    input  alu_src_sel, alu_op, reg_write, wb_sel, mem_read, mem_write,
           ir_write, pc_write, pc_src, halted, mem_error, illegal_op, state
  );
endinterface
`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_fsm
// Description : Multi-cycle fetch/decode/execute/memory/writeback sequencer.
// Revision    : 1.0
// ============================================================================
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  cpu_ctrl_fsm_if.master bus
);

  localparam logic [3:0] C_FETCH    = 4'h0;
  localparam logic [3:0] C_DECODE   = 4'h1;
  localparam logic [3:0] C_EXEC_R   = 4'h2;
  localparam logic [3:0] C_EXEC_I   = 4'h3;
  localparam logic [3:0] C_WB_ALU   = 4'h4;
  localparam logic [3:0] C_MEM_ADDR = 4'h5;
  localparam logic [3:0] C_MEM_RD   = 4'h6;
  localparam logic [3:0] C_WB_MEM   = 4'h7;
  localparam logic [3:0] C_MEM_WR   = 4'h8;
  localparam logic [3:0] C_BRANCH   = 4'h9;
  localparam logic [3:0] C_JUMP     = 4'hA;
  localparam logic [3:0] C_HALT     = 4'hB;

  localparam logic [3:0] C_OP_SW    = 4'h6;
  localparam logic [7:0] C_TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [3:0] r_state;
  logic [3:0] w_state_next;
  logic [7:0] r_wait_cnt;
  logic       r_mem_error;
  logic       r_hold_src;
  logic [1:0] r_hold_op;
  logic       w_waiting;
  logic       w_timeout;

  logic       w_alu_src_sel;
  logic [1:0] w_alu_op;
  logic       w_reg_write;
  logic       w_wb_sel;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_halted;
  logic       w_illegal_op;

  assign w_waiting = (r_state == C_FETCH) || (r_state == C_MEM_RD) || (r_state == C_MEM_WR);
  assign w_timeout = w_waiting && !bus.mem_ready && (r_wait_cnt == C_TMO_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_FETCH:    if (bus.mem_ready) w_state_next = C_DECODE;
      C_DECODE: begin
        case (bus.opcode)
          4'h0, 4'h1, 4'h2, 4'h3: w_state_next = C_EXEC_R;
          4'h4:                   w_state_next = C_EXEC_I;
          4'h5, 4'h6:             w_state_next = C_MEM_ADDR;
          4'h7:                   w_state_next = C_BRANCH;
          4'h8:                   w_state_next = C_JUMP;
          4'hF:                   w_state_next = C_HALT;
          default:                w_state_next = C_FETCH;
        endcase
      end
      C_EXEC_R, C_EXEC_I: w_state_next = C_WB_ALU;
      C_MEM_ADDR: w_state_next = (bus.opcode == C_OP_SW) ? C_MEM_WR : C_MEM_RD;
      C_MEM_RD:   if (bus.mem_ready) w_state_next = C_WB_MEM;
      C_MEM_WR:   if (bus.mem_ready) w_state_next = C_FETCH;
      C_WB_ALU, C_WB_MEM, C_BRANCH, C_JUMP: w_state_next = C_FETCH;
      C_HALT:     w_state_next = C_HALT;
      default:    w_state_next = C_FETCH;
    endcase
    // Timeout takes priority over staying put in any of the waiting states
    if (w_timeout) w_state_next = C_HALT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= C_FETCH;
      r_wait_cnt  <= 8'd0;
      r_mem_error <= 1'b0;
      r_hold_src  <= 1'b0;
      r_hold_op   <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state)
        r_wait_cnt <= 8'd0;
      else if (w_waiting && !bus.mem_ready)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout)
        r_mem_error <= 1'b1;
      // WB_ALU replays the ALU controls of the execute cycle before it
      if (r_state == C_EXEC_R) begin
        r_hold_src <= 1'b0;
        r_hold_op  <= bus.opcode[1:0];
      end else if (r_state == C_EXEC_I) begin
        r_hold_src <= 1'b1;
        r_hold_op  <= 2'b00;
      end
    end
  end

  always_comb begin
    w_alu_src_sel = 1'b0;
    w_alu_op      = 2'b00;
    w_reg_write   = 1'b0;
    w_wb_sel      = 1'b0;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_pc_src      = 2'b00;
    w_halted      = 1'b0;
    w_illegal_op  = 1'b0;
    case (r_state)
      C_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = bus.mem_ready;
        w_pc_write = bus.mem_ready;
      end
      C_DECODE: begin
        case (bus.opcode)
          4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: w_illegal_op = 1'b1;
          default:                            w_illegal_op = 1'b0;
        endcase
      end
      C_EXEC_R:   w_alu_op = bus.opcode[1:0];
      C_EXEC_I:   w_alu_src_sel = 1'b1;
      C_WB_ALU: begin
        w_reg_write   = 1'b1;
        w_alu_src_sel = r_hold_src;
        w_alu_op      = r_hold_op;
      end
      C_MEM_ADDR: w_alu_src_sel = 1'b1;
      C_MEM_RD: begin
        w_mem_read    = 1'b1;
        w_alu_src_sel = 1'b1;
      end
      C_WB_MEM: begin
        w_reg_write = 1'b1;
        w_wb_sel    = 1'b1;
      end
      C_MEM_WR: begin
        w_mem_write   = 1'b1;
        w_alu_src_sel = 1'b1;
      end
      C_BRANCH: begin
        w_alu_op   = 2'b01;
        w_pc_src   = 2'b01;
        w_pc_write = bus.zero;
      end
      C_JUMP: begin
        w_pc_write = 1'b1;
        w_pc_src   = 2'b10;
      end
      C_HALT:     w_halted = 1'b1;
      default:    w_halted = 1'b0;
    endcase
  end

  // Enables are suppressed in the reset cycle so an abandoned instruction commits nothing
  assign bus.reg_write   = w_reg_write & rst_n;
  assign bus.mem_write   = w_mem_write & rst_n;
  assign bus.ir_write    = w_ir_write & rst_n;
  assign bus.pc_write    = w_pc_write & rst_n;
  assign bus.alu_src_sel = w_alu_src_sel;
  assign bus.alu_op      = w_alu_op;
  assign bus.wb_sel      = w_wb_sel;
  assign bus.mem_read    = w_mem_read;
  assign bus.pc_src      = w_pc_src;
  assign bus.halted      = w_halted;
  assign bus.illegal_op  = w_illegal_op;
  assign bus.mem_error   = r_mem_error;
  assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ctrl_fsm
// Description : Scoreboard bench; expected per-cycle outputs built per instruction.
// Revision    : 1.0
// ============================================================================
module tb_cpu_ctrl_fsm;
  localparam int T = 15;

  // Expected-vector field layout: {state, src, aop, rw, wb, mr, mw, irw, pcw, pcs, halted, merr, ill}
  localparam logic [17:0] c_src  = 18'(1) << 13;
  localparam logic [17:0] c_rw   = 18'(1) << 10;
  localparam logic [17:0] c_wb   = 18'(1) << 9;
  localparam logic [17:0] c_mr   = 18'(1) << 8;
  localparam logic [17:0] c_mw   = 18'(1) << 7;
  localparam logic [17:0] c_irw  = 18'(1) << 6;
  localparam logic [17:0] c_pcw  = 18'(1) << 5;
  localparam logic [17:0] c_hlt  = 18'(1) << 2;
  localparam logic [17:0] c_merr = 18'(1) << 1;
  localparam logic [17:0] c_ill  = 18'(1);
  localparam logic [17:0] c_all  = '1;
  localparam logic [17:0] c_we   = c_rw | c_mw | c_irw | c_pcw;
  localparam logic [17:0] c_stm  = 18'h3C000;

  typedef struct {
    logic [17:0] exp;
    logic [17:0] mask;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cpu_ctrl_fsm_if bus();

  cpu_ctrl_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ent_t sb[$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;

  function automatic logic [17:0] st(input int s);
    return 18'(s) << 14;
  endfunction
  function automatic logic [17:0] aop(input logic [1:0] v);
    return 18'(v) << 11;
  endfunction
  function automatic logic [17:0] pcs(input logic [1:0] v);
    return 18'(v) << 3;
  endfunction

  // Monitor: every cycle the DUT presents a vector that the scoreboard must explain
  always @(negedge clk) begin
    ent_t e;
    logic [17:0] act;
    cycle++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {bus.state, bus.alu_src_sel, bus.alu_op, bus.reg_write, bus.wb_sel,
             bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_src,
             bus.halted, bus.mem_error, bus.illegal_op};
      checks++;
      if (((act ^ e.exp) & e.mask) !== 18'd0) begin
        failures++;
        $display("FAIL outputs cycle=%0d got=%05h expected=%05h mask=%05h",
                 cycle, act, e.exp, e.mask);
      end
    end
  end

  task automatic cyc(input bit rdy, input bit z, input logic [17:0] e, input logic [17:0] m = c_all);
    ent_t n;
    bus.mem_ready = rdy;
    bus.zero      = z;
    n.exp  = e;
    n.mask = m;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  // s < 0: DUT state is not known (power-up), so only the enables are checked
  task automatic reset_cycle(input int s);
    rst_n = 1'b0;
    cyc(1'($urandom), 1'($urandom), (s >= 0) ? st(s) : 18'd0,
        (s >= 0) ? (c_we | c_stm) : c_we);
    rst_n = 1'b1;
  endtask

  task automatic halt_tail(input bit merr, input int n);
    for (int i = 0; i < n; i++) begin
      bus.opcode = 4'($urandom);
      cyc(1'($urandom), 1'($urandom), st(11) | c_hlt | (merr ? c_merr : 18'd0));
    end
    reset_cycle(11);
  endtask

  // One instruction: fw/mw are memory wait cycles for fetch and data phases;
  // a wait of T or more means memory never answers. abort >= 0 resets during the data wait.
  task automatic run_instr(input logic [3:0] op, input bit z, input int fw, input int mw,
                           input int abort = -1);
    int ms;
    for (int i = 0; i < fw && i < T; i++) begin
      bus.opcode = 4'($urandom);
      cyc(1'b0, 1'($urandom), st(0) | c_mr);
    end
    if (fw >= T) begin
      halt_tail(1'b1, 3);
      return;
    end
    bus.opcode = 4'($urandom);
    cyc(1'b1, 1'($urandom), st(0) | c_mr | c_irw | c_pcw);
    bus.opcode = op;
    cyc(1'($urandom), 1'($urandom), st(1) | ((op >= 4'h9 && op <= 4'hE) ? c_ill : 18'd0));
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        cyc(1'($urandom), 1'($urandom), st(2) | aop(op[1:0]));
        cyc(1'($urandom), 1'($urandom), st(4) | aop(op[1:0]) | c_rw);
      end
      4'h4: begin
        cyc(1'($urandom), 1'($urandom), st(3) | c_src);
        cyc(1'($urandom), 1'($urandom), st(4) | c_src | c_rw);
      end
      4'h5, 4'h6: begin
        ms = (op == 4'h5) ? 6 : 8;
        cyc(1'($urandom), 1'($urandom), st(5) | c_src);
        for (int i = 0; i < mw && i < T; i++) begin
          if (i == abort) begin
            reset_cycle(ms);
            return;
          end
          cyc(1'b0, 1'($urandom), st(ms) | c_src | ((op == 4'h5) ? c_mr : c_mw));
        end
        if (mw >= T) begin
          halt_tail(1'b1, 3);
          return;
        end
        cyc(1'b1, 1'($urandom), st(ms) | c_src | ((op == 4'h5) ? c_mr : c_mw));
        if (op == 4'h5)
          cyc(1'($urandom), 1'($urandom), st(7) | c_rw | c_wb);
      end
      4'h7: cyc(1'($urandom), z, st(9) | aop(2'b01) | pcs(2'b01) | (z ? c_pcw : 18'd0));
      4'h8: cyc(1'($urandom), 1'($urandom), st(10) | c_pcw | pcs(2'b10));
      4'hF: halt_tail(1'b0, 22);
      default: ;
    endcase
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 3) return T + int'($urandom_range(0, 3));
    if (r < 6) return T - 1;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    bus.opcode    = 4'h0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_cycle(-1);
    reset_cycle(0);

    run_instr(4'h0, 1'b0, 0, 0);          // ADD: 0,1,2,4
    run_instr(4'h4, 1'b0, 0, 0);          // ADDI
    run_instr(4'h5, 1'b0, 0, 3);          // LW with 3 wait cycles
    run_instr(4'h7, 1'b1, 0, 0);          // BEQ taken
    run_instr(4'h7, 1'b0, 0, 0);          // BEQ not taken
    run_instr(4'hA, 1'b0, 0, 0);          // illegal
    run_instr(4'h6, 1'b0, 0, T);          // SW timeout -> HALT, mem_error
    run_instr(4'h6, 1'b0, 0, T - 1);      // SW ready on terminal count
    run_instr(4'h6, 1'b0, 0, 6, 2);       // reset during MEM_WR wait
    run_instr(4'h1, 1'b0, 2, 0);
    run_instr(4'hF, 1'b0, 0, 0);          // HALT held 22 cycles
    run_instr(4'h0, 1'b0, T, 0);          // fetch timeout

    for (int n = 0; n < 200; n++)
      run_instr(4'($urandom), 1'($urandom), pick_wait(), pick_wait());

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t expected=finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
